// File: rtl/fetch_controller_pkg.sv
// Shared constants and FSM encoding for the instruction fetch controller.
// Holds the address width, reset PC, reset instruction word and the fetch state type.
// Imported by fetch_controller and fetch_pc_reg.
package fetch_controller_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_VALID = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC mux: hold, +4, or redirect target.
// Ports: clock/reset (async active-low), load_redirect + redirect_pc, advance, pc.
// A redirect always wins over advance; the target is forced to word alignment.
module fetch_pc_reg
    import fetch_controller_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            load_redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc
);

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    logic [XLEN-1:0] pc_next;

    always_comb begin
        pc_next = pc;
        if (load_redirect) begin
            pc_next = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (advance) begin
            pc_next = pc + PC_STEP;   // wraps modulo 2^XLEN
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, keeps one request outstanding to imem,
// and presents each returned word to decode with a valid/ready handshake.
// Ports: run, redirect, imem req/ready/rvalid/rdata, instr valid/ready/data/pc, busy, fetch_count.
module fetch_controller
    import fetch_controller_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            busy,
    output logic [31:0]     fetch_count
);

    fetch_state_t    state, state_next;
    logic            drop, drop_next;
    logic            capture;
    logic            advance;
    logic            handshake;
    logic [XLEN-1:0] pc;

    fetch_pc_reg u_pc (
        .clock         (clock),
        .reset         (reset),
        .load_redirect (redirect_valid),
        .redirect_pc   (redirect_pc),
        .advance       (advance),
        .pc            (pc)
    );

    always_comb begin
        state_next = state;
        drop_next  = drop;
        capture    = 1'b0;
        advance    = 1'b0;
        handshake  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ready) begin
                    state_next = ST_WAIT;
                    // Accepted while being redirected: the response belongs to the old path.
                    if (redirect_valid) drop_next = 1'b1;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (drop || redirect_valid) begin
                        drop_next  = 1'b0;
                        state_next = run ? ST_REQ : ST_IDLE;
                    end else begin
                        capture    = 1'b1;
                        advance    = 1'b1;
                        state_next = ST_VALID;
                    end
                end else if (redirect_valid) begin
                    drop_next = 1'b1;
                end
            end
            ST_VALID: begin
                handshake = instr_ready;
                // A redirect retires the buffered word even if decode did not take it.
                if (instr_ready || redirect_valid) begin
                    state_next = run ? ST_REQ : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            drop        <= 1'b0;
            instr       <= NOP_INSTR;
            instr_pc    <= RESET_PC;
            fetch_count <= 32'd0;
        end else begin
            state <= state_next;
            drop  <= drop_next;
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            if (handshake) fetch_count <= fetch_count + 32'd1;
        end
    end

    assign imem_req    = (state == ST_REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state == ST_VALID);
    assign busy        = (state != ST_IDLE);

    // A response outside WAIT has no matching request; it is ignored above.
    rvalid_in_wait: assert property (@(posedge clock) disable iff (!reset)
        imem_rvalid |-> (state == ST_WAIT))
        else $error("imem_rvalid asserted while no request outstanding");

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: hand-computed expectations checked after each clock.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// Prints one summary line with check and error counts.
module tb_fetch_controller;
    import fetch_controller_pkg::*;

    logic            clock = 1'b0;
    logic            reset;
    logic            run;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            instr_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            busy;
    logic [31:0]     fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    fetch_controller dut (
        .clock          (clock),
        .reset          (reset),
        .run            (run),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .busy           (busy),
        .fetch_count    (fetch_count)
    );

    always #5 clock = ~clock;

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish before 20000 ns");
        $fatal(1, "simulation timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
        chk({tag, "_addr"},  imem_addr,            32'h0);
        chk({tag, "_vld"},   {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr,                32'h0000_0013);
        chk({tag, "_ipc"},   instr_pc,             32'h0);
        chk({tag, "_busy"},  {31'd0, busy},        32'd0);
        chk({tag, "_cnt"},   fetch_count,          32'd0);
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        step(); step();
        chk_reset_vals("rst");

        // 1: basic fetch, minimum latency
        reset = 1'b1; run = 1'b1; imem_ready = 1'b1;
        step();                                   // IDLE -> REQ
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr0", imem_addr, 32'h0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        step();                                   // accepted -> WAIT
        imem_ready = 1'b0;
        chk("t1_wait_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        step();                                   // capture -> VALID
        imem_rvalid = 1'b0;
        chk("t1_vld", {31'd0, instr_valid}, 32'd1);
        chk("t1_instr", instr, 32'h0050_0093);
        chk("t1_ipc", instr_pc, 32'h0);
        chk("t1_addr4", imem_addr, 32'h4);

        // 2: decode stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_instr", instr, 32'h0050_0093);
            chk("t2_ipc", instr_pc, 32'h0);
            chk("t2_req", {31'd0, imem_req}, 32'd0);
            chk("t2_cnt", fetch_count, 32'd0);
        end
        instr_ready = 1'b1;
        step();                                   // handshake -> REQ
        instr_ready = 1'b0;
        chk("t2_cnt1", fetch_count, 32'd1);
        chk("t2_vld0", {31'd0, instr_valid}, 32'd0);
        chk("t2_addr", imem_addr, 32'h4);

        // 3: redirect while waiting, stale response dropped
        imem_ready = 1'b1;
        step();                                   // accept @4 -> WAIT
        imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();                                   // drop armed, pc = 0x100
        redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();                                   // discarded -> REQ
        imem_rvalid = 1'b0;
        chk("t3_vld0", {31'd0, instr_valid}, 32'd0);
        chk("t3_req", {31'd0, imem_req}, 32'd1);
        chk("t3_addr", imem_addr, 32'h100);
        chk("t3_instr_kept", instr, 32'h0050_0093);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0113;
        step();
        imem_rvalid = 1'b0;
        chk("t3_vld", {31'd0, instr_valid}, 32'd1);
        chk("t3_ipc", instr_pc, 32'h100);
        chk("t3_instr", instr, 32'h0000_0113);
        chk("t3_addr_next", imem_addr, 32'h104);

        // 4: redirect in VALID together with instr_ready
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        instr_ready = 1'b0; redirect_valid = 1'b0;
        chk("t4_cnt", fetch_count, 32'd2);
        chk("t4_vld0", {31'd0, instr_valid}, 32'd0);
        chk("t4_req", {31'd0, imem_req}, 32'd1);
        chk("t4_addr", imem_addr, 32'h100);

        // 5: misaligned redirect near the top of memory, then wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();                                   // REQ not accepted, addr updates
        redirect_valid = 1'b0;
        chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
        chk("t5_req", {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0020_0093;
        step();
        imem_rvalid = 1'b0;
        chk("t5_ipc", instr_pc, 32'hFFFF_FFFC);
        chk("t5_vld", {31'd0, instr_valid}, 32'd1);
        chk("t5_wrap", imem_addr, 32'h0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("t5_cnt", fetch_count, 32'd3);
        chk("t5_addr_next", imem_addr, 32'h0);

        // 6: asynchronous reset while waiting
        imem_ready = 1'b1;
        step();                                   // -> WAIT
        imem_ready = 1'b0;
        chk("t6_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk_reset_vals("t6_async");
        step();
        reset = 1'b1;
        step();                                   // IDLE -> REQ
        chk("t6_vld_req", {31'd0, instr_valid}, 32'd0);
        chk("t6_req", {31'd0, imem_req}, 32'd1);
        step();                                   // still REQ, not accepted
        chk("t6_vld_hold", {31'd0, instr_valid}, 32'd0);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("t6_vld_wait", {31'd0, instr_valid}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0030_0093;
        step();
        imem_rvalid = 1'b0;
        chk("t6_vld", {31'd0, instr_valid}, 32'd1);
        chk("t6_instr", instr, 32'h0030_0093);
        chk("t6_ipc", instr_pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
